// File: rtl/vga_grid_decoder.sv
// rtl/vga_grid_decoder.sv - VGA stream monitor that decodes the Game-of-Life cell grid
//
// Samples the centre pixel of every GRID_SIZE x GRID_SIZE cell in the incoming
// VGA stream, writes the decoded alive/dead state to an external grid store in
// row-major order, counts decoded frames and flags malformed frame geometry.
//
// Ports:
//   pixel_clock              pixel clock, all logic on its rising edge
//   rst_n                    asynchronous active-low reset
//   i_enable                 capture enable, low forces IDLE
//   i_err_clr                synchronous clear of o_geom_err
//   i_hsync_n, i_vsync_n     active-low syncs
//   i_hblank_n, i_vblank_n   high during the horizontal / vertical active region
//   i_r, i_g, i_b            4-bit pixel colour
//   o_cell_we                one-cycle write strobe to the grid store
//   o_cell_row, o_cell_col   cell index of the write
//   o_cell_alive             decoded cell state
//   o_frame_done             one-cycle pulse per completely decoded frame
//   o_frame_count            decoded frame counter, wraps 255->0
//   o_geom_err               sticky geometry error
//   o_busy                   high while waiting for or capturing a frame
module vga_grid_decoder #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int GRID_SIZE = 20,
    parameter int CELL_W    = 32,
    parameter int CELL_H    = 24,
    parameter int LIT_SUM   = 24
) (
    input  logic       pixel_clock,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_err_clr,
    input  logic       i_hsync_n,
    input  logic       i_vsync_n,
    input  logic       i_hblank_n,
    input  logic       i_vblank_n,
    input  logic [3:0] i_r,
    input  logic [3:0] i_g,
    input  logic [3:0] i_b,
    output logic       o_cell_we,
    output logic [4:0] o_cell_row,
    output logic [4:0] o_cell_col,
    output logic       o_cell_alive,
    output logic       o_frame_done,
    output logic [7:0] o_frame_count,
    output logic       o_geom_err,
    output logic       o_busy
);

    localparam logic [9:0] H_LEN   = 10'(H_ACTIVE);
    localparam logic [8:0] V_LEN   = 9'(V_ACTIVE);
    localparam logic [9:0] CW_LAST = 10'(CELL_W - 1);
    localparam logic [9:0] CW_MID  = 10'(CELL_W / 2);
    localparam logic [8:0] CH_LAST = 9'(CELL_H - 1);
    localparam logic [8:0] CH_MID  = 9'(CELL_H / 2);
    localparam logic [4:0] GRID    = 5'(GRID_SIZE);
    localparam logic [5:0] LIT     = 6'(LIT_SUM);

    typedef enum logic [1:0] {IDLE, WAIT_ACTIVE, CAPTURE, CHECK} state_t;

    state_t     state, state_next;
    logic       enable_q, err_clr_q, hsync_n_q, vsync_n_q, hblank_n_q, vblank_n_q;
    logic [3:0] r_q, g_q, b_q;
    logic       vsync_prev, hblank_prev, vblank_prev;
    logic [9:0] x_cnt, sub_x;
    logic [8:0] y_cnt, sub_y;
    logic [4:0] col, row;
    logic       active, vsync_fall, hblank_fall, vblank_fall;
    logic       sample_hit, geom_set;
    logic [5:0] pix_sum;

    // Input registers; the *_prev copies are the edge-detection history.
    // Resetting syncs/blanks to 0 means no edge can be invented at reset
    // release, so capture only starts on a genuine vsync falling edge.
    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            enable_q    <= 1'b0;
            err_clr_q   <= 1'b0;
            hsync_n_q   <= 1'b0;
            vsync_n_q   <= 1'b0;
            hblank_n_q  <= 1'b0;
            vblank_n_q  <= 1'b0;
            r_q         <= 4'd0;
            g_q         <= 4'd0;
            b_q         <= 4'd0;
            vsync_prev  <= 1'b0;
            hblank_prev <= 1'b0;
            vblank_prev <= 1'b0;
        end else begin
            enable_q    <= i_enable;
            err_clr_q   <= i_err_clr;
            hsync_n_q   <= i_hsync_n;
            vsync_n_q   <= i_vsync_n;
            hblank_n_q  <= i_hblank_n;
            vblank_n_q  <= i_vblank_n;
            r_q         <= i_r;
            g_q         <= i_g;
            b_q         <= i_b;
            vsync_prev  <= vsync_n_q;
            hblank_prev <= hblank_n_q;
            vblank_prev <= vblank_n_q;
        end
    end

    assign active      = hblank_n_q & vblank_n_q;
    assign vsync_fall  = vsync_prev & ~vsync_n_q;
    assign hblank_fall = hblank_prev & ~hblank_n_q;
    assign vblank_fall = vblank_prev & ~vblank_n_q;
    assign pix_sum     = {2'b00, r_q} + {2'b00, g_q} + {2'b00, b_q};

    // x/y give the position of the pixel currently in the input registers.
    // sub_x/col and sub_y/row track the same position split into cell index
    // and offset inside the cell; col/row saturate at GRID so an over-long
    // line or frame cannot alias back onto a valid cell.
    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= 10'd0;
            sub_x <= 10'd0;
            col   <= 5'd0;
            y_cnt <= 9'd0;
            sub_y <= 9'd0;
            row   <= 5'd0;
        end else if (enable_q) begin
            if (active) begin
                x_cnt <= x_cnt + 10'd1;
                if (sub_x == CW_LAST) begin
                    sub_x <= 10'd0;
                    if (col < GRID) col <= col + 5'd1;
                end else begin
                    sub_x <= sub_x + 10'd1;
                end
            end else begin
                x_cnt <= 10'd0;
                sub_x <= 10'd0;
                col   <= 5'd0;
            end
            if (vsync_fall) begin
                y_cnt <= 9'd0;
                sub_y <= 9'd0;
                row   <= 5'd0;
            end else if (hblank_fall && vblank_n_q) begin
                y_cnt <= y_cnt + 9'd1;
                if (sub_y == CH_LAST) begin
                    sub_y <= 9'd0;
                    if (row < GRID) row <= row + 5'd1;
                end else begin
                    sub_y <= sub_y + 9'd1;
                end
            end
        end
    end

    assign sample_hit = enable_q && (state == CAPTURE) && active &&
                        (sub_x == CW_MID) && (col < GRID) &&
                        (sub_y == CH_MID) && (row < GRID);

    always_comb begin
        state_next = state;
        geom_set   = 1'b0;
        case (state)
            IDLE: begin
                if (vsync_fall) state_next = WAIT_ACTIVE;
            end
            WAIT_ACTIVE: begin
                if (active) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (vsync_fall) begin
                    geom_set   = 1'b1;
                    state_next = WAIT_ACTIVE;
                end else if (vblank_fall) begin
                    if (y_cnt == V_LEN) begin
                        state_next = CHECK;
                    end else begin
                        geom_set   = 1'b1;
                        state_next = WAIT_ACTIVE;
                    end
                end
                if (hblank_fall && vblank_n_q && (x_cnt != H_LEN)) geom_set = 1'b1;
                // A horizontal sync inside the active region is malformed timing.
                if (active && !hsync_n_q) geom_set = 1'b1;
            end
            CHECK: begin
                state_next = WAIT_ACTIVE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!enable_q) begin
            state_next = IDLE;
            geom_set   = 1'b0;
        end
    end

    always_ff @(posedge pixel_clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            o_cell_we     <= 1'b0;
            o_cell_row    <= 5'd0;
            o_cell_col    <= 5'd0;
            o_cell_alive  <= 1'b0;
            o_frame_count <= 8'd0;
            o_geom_err    <= 1'b0;
        end else begin
            state     <= state_next;
            o_cell_we <= sample_hit;
            if (sample_hit) begin
                o_cell_row   <= row;
                o_cell_col   <= col;
                o_cell_alive <= (pix_sum >= LIT);
            end
            if (state == CHECK) o_frame_count <= o_frame_count + 8'd1;
            // A new error outranks a clear in the same cycle.
            if (geom_set) begin
                o_geom_err <= 1'b1;
            end else if (err_clr_q) begin
                o_geom_err <= 1'b0;
            end
        end
    end

    assign o_frame_done = (state == CHECK);
    assign o_busy       = (state == WAIT_ACTIVE) || (state == CAPTURE);

endmodule

// File: tb/tb_vga_grid_decoder.sv
// tb/tb_vga_grid_decoder.sv - randomized self-checking bench for vga_grid_decoder
module tb_vga_grid_decoder;

    localparam int HA  = 16;
    localparam int VA  = 8;
    localparam int GS  = 4;
    localparam int CW  = 4;
    localparam int CH  = 2;
    localparam int LIT = 24;
    localparam int HT  = 22;
    localparam int VB  = 2;

    logic       pixel_clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_err_clr = 1'b0;
    logic       i_hsync_n = 1'b1;
    logic       i_vsync_n = 1'b1;
    logic       i_hblank_n = 1'b0;
    logic       i_vblank_n = 1'b0;
    logic [3:0] i_r = 4'd0;
    logic [3:0] i_g = 4'd0;
    logic [3:0] i_b = 4'd0;
    logic       o_cell_we;
    logic [4:0] o_cell_row;
    logic [4:0] o_cell_col;
    logic       o_cell_alive;
    logic       o_frame_done;
    logic [7:0] o_frame_count;
    logic       o_geom_err;
    logic       o_busy;

    vga_grid_decoder #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .GRID_SIZE(GS),
        .CELL_W(CW), .CELL_H(CH), .LIT_SUM(LIT)
    ) dut (
        .pixel_clock(pixel_clock), .rst_n(rst_n), .i_enable(i_enable),
        .i_err_clr(i_err_clr), .i_hsync_n(i_hsync_n), .i_vsync_n(i_vsync_n),
        .i_hblank_n(i_hblank_n), .i_vblank_n(i_vblank_n),
        .i_r(i_r), .i_g(i_g), .i_b(i_b),
        .o_cell_we(o_cell_we), .o_cell_row(o_cell_row), .o_cell_col(o_cell_col),
        .o_cell_alive(o_cell_alive), .o_frame_done(o_frame_done),
        .o_frame_count(o_frame_count), .o_geom_err(o_geom_err), .o_busy(o_busy)
    );

    always #5 pixel_clock = ~pixel_clock;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_seen = 0;
    int          extra_writes = 0;
    int          lat_mark = -1;
    bit          lat_on = 1'b0;
    logic [10:0] exp_q[$];
    logic [7:0]  exp_count = 8'd0;
    logic        exp_err = 1'b0;
    logic [3:0]  cr[GS][GS];
    logic [3:0]  cg[GS][GS];
    logic [3:0]  cb[GS][GS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel period: observe outputs at the falling edge, then the caller drives.
    task automatic step();
        logic [10:0] e;
        @(negedge pixel_clock);
        cyc++;
        if (o_frame_done === 1'b1) done_seen++;
        if (o_cell_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                extra_writes++;
            end else begin
                e = exp_q.pop_front();
                check("cell_write", {21'd0, o_cell_row, o_cell_col, o_cell_alive}, {21'd0, e});
                if (lat_on && o_cell_row == 5'd2 && o_cell_col == 5'd3)
                    check("write_latency", cyc - lat_mark, 2);
            end
        end
    endtask

    task automatic idle(input int n, input bit clr);
        for (int k = 0; k < n; k++) begin
            step();
            i_err_clr  = clr && (k == 0);
            i_vsync_n  = 1'b1;
            i_hsync_n  = 1'b1;
            i_vblank_n = 1'b0;
            i_hblank_n = 1'b0;
        end
    endtask

    task automatic fill_all(input logic [3:0] rv, input logic [3:0] gv, input logic [3:0] bv);
        for (int r = 0; r < GS; r++)
            for (int c = 0; c < GS; c++) begin
                cr[r][c] = rv; cg[r][c] = gv; cb[r][c] = bv;
            end
    endtask

    task automatic random_cells();
        for (int r = 0; r < GS; r++)
            for (int c = 0; c < GS; c++) begin
                cr[r][c] = 4'($urandom_range(0, 15));
                cg[r][c] = 4'($urandom_range(0, 15));
                cb[r][c] = 4'($urandom_range(0, 15));
            end
    endtask

    // Frame layout: line 0 vsync, line 1 blank, VA active lines, one blank tail line.
    // cut_kind: 0 none, 1 enable dropped at active line cut_line, 2 reset pulse there.
    task automatic run_frame(input int short_line, input int short_len, input int clr_line,
                             input int cut_line, input int cut_kind, input bit noise);
        bit         decode;
        bit         act_line;
        int         ay, len, sx, row;
        logic [3:0] r, g, b;
        decode       = i_enable;
        done_seen    = 0;
        extra_writes = 0;
        for (int y = 0; y < VA; y++) begin
            if (y % CH == CH / 2 && decode && (cut_kind == 0 || y < cut_line)) begin
                row = y / CH;
                len = (y == short_line) ? short_len : HA;
                for (int c = 0; c < GS; c++) begin
                    sx = c * CW + CW / 2;
                    if (sx < len)
                        exp_q.push_back({5'(row), 5'(c),
                            (int'(cr[row][c]) + int'(cg[row][c]) + int'(cb[row][c])) >= LIT});
                end
            end
        end
        for (int line = 0; line < VB + VA + 1; line++) begin
            act_line = (line >= VB) && (line < VB + VA);
            ay       = line - VB;
            len      = (act_line && ay == short_line) ? short_len : HA;
            for (int px = 0; px < HT; px++) begin
                step();
                if (cut_kind == 2 && act_line && ay == cut_line) begin
                    if (px == 0) rst_n = 1'b0;
                    if (px == 5) rst_n = 1'b1;
                end
                if (cut_kind == 1 && act_line && ay == cut_line && px == 0) i_enable = 1'b0;
                i_err_clr  = act_line && (ay == clr_line) && (px == len);
                i_vsync_n  = (line != 0);
                i_vblank_n = act_line;
                i_hblank_n = (px < len);
                i_hsync_n  = !(px >= len + 2 && px < len + 4);
                if (act_line && px < len) begin
                    if (noise && !(ay % CH == CH / 2 && px % CW == CW / 2)) begin
                        r = 4'($urandom_range(0, 15));
                        g = 4'($urandom_range(0, 15));
                        b = 4'($urandom_range(0, 15));
                    end else begin
                        r = cr[ay / CH][px / CW];
                        g = cg[ay / CH][px / CW];
                        b = cb[ay / CH][px / CW];
                    end
                    if (ay == 2 * CH + CH / 2 && px == 3 * CW + CW / 2) lat_mark = cyc;
                end else begin
                    r = 4'($urandom_range(0, 15));
                    g = 4'($urandom_range(0, 15));
                    b = 4'($urandom_range(0, 15));
                end
                i_r = r; i_g = g; i_b = b;
            end
        end
        if (cut_kind == 2) begin
            exp_count = 8'd0;
            exp_err   = 1'b0;
        end else begin
            if (decode && cut_kind == 0) exp_count = exp_count + 8'd1;
            if (decode && short_line >= 0 && (cut_kind == 0 || short_line < cut_line))
                exp_err = 1'b1;
            else if (clr_line >= 0)
                exp_err = 1'b0;
        end
        check("writes_missing", exp_q.size(), 0);
        check("writes_extra", extra_writes, 0);
        check("frame_done_pulses", done_seen, (decode && cut_kind == 0) ? 1 : 0);
        check("frame_count", o_frame_count, exp_count);
        check("geom_err", o_geom_err, exp_err);
        check("busy", o_busy, decode && cut_kind == 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_cell_we", o_cell_we, 0);
        check("rst_cell_row", o_cell_row, 0);
        check("rst_cell_col", o_cell_col, 0);
        check("rst_cell_alive", o_cell_alive, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_frame_count", o_frame_count, 0);
        check("rst_geom_err", o_geom_err, 0);
        check("rst_busy", o_busy, 0);
        rst_n    = 1'b1;
        i_enable = 1'b1;
        idle(5, 1'b0);

        // Checkerboard, full white / black
        for (int r = 0; r < GS; r++)
            for (int c = 0; c < GS; c++) begin
                cr[r][c] = ((r + c) % 2 == 1) ? 4'hF : 4'h0;
                cg[r][c] = cr[r][c];
                cb[r][c] = cr[r][c];
            end
        run_frame(-1, 0, -1, 0, 0, 1'b0);

        // Single lit cell (2,3) with write-latency check
        fill_all(4'h0, 4'h0, 4'h0);
        cr[2][3] = 4'hF; cg[2][3] = 4'hF; cb[2][3] = 4'hF;
        lat_on = 1'b1;
        run_frame(-1, 0, -1, 0, 0, 1'b0);
        lat_on = 1'b0;

        // Threshold: sum 23 then 24 alternating
        for (int r = 0; r < GS; r++)
            for (int c = 0; c < GS; c++) begin
                cr[r][c] = 4'd8; cg[r][c] = 4'd8;
                cb[r][c] = ((r + c) % 2 == 0) ? 4'd7 : 4'd8;
            end
        run_frame(-1, 0, -1, 0, 0, 1'b0);

        // Random colours with noisy off-centre pixels
        for (int k = 0; k < 3; k++) begin
            random_cells();
            run_frame(-1, 0, -1, 0, 0, 1'b1);
        end

        // Short line sets the sticky error; it survives a good frame
        random_cells();
        run_frame(3, HA - 1, -1, 0, 0, 1'b1);
        random_cells();
        run_frame(-1, 0, -1, 0, 0, 1'b1);
        idle(4, 1'b1);
        exp_err = 1'b0;
        check("err_after_clear", o_geom_err, exp_err);

        // Clear coincident with a new error keeps the flag set
        random_cells();
        run_frame(5, HA - 1, 5, 0, 0, 1'b1);

        // Reset mid-frame, then a full frame decodes
        random_cells();
        run_frame(-1, 0, -1, 4, 2, 1'b1);
        random_cells();
        run_frame(-1, 0, -1, 0, 0, 1'b1);

        // Enable dropped mid-frame, then re-enabled
        random_cells();
        run_frame(-1, 0, -1, 5, 1, 1'b1);
        i_enable = 1'b1;
        random_cells();
        run_frame(-1, 0, -1, 0, 0, 1'b1);

        // Run until the frame counter wraps
        for (int k = 0, n = 256 - int'(exp_count); k < n; k++) begin
            random_cells();
            run_frame(-1, 0, -1, 0, 0, 1'b1);
        end
        check("frame_count_wrap", o_frame_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
